// File: rtl/mem_access_pkg.sv
// Shared encodings for the AHB-lite MEM stage: bus transfer types,
// access sizes, FSM states and an alignment helper.
package mem_access_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_e;

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [2:0] a);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            SZ_W:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero
// extension for loads, parametrised by XLEN (32 or 64).
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic [XLEN-1:0]           rdata_i,
    output logic [XLEN-1:0]           wlane_o,
    output logic [XLEN-1:0]           rdata_o
);

    logic [XLEN-1:0] sh;
    logic [63:0]     sh64;
    logic [63:0]     ext;

    assign wlane_o = wdata_i << {offset_i, 3'b000};
    assign sh      = rdata_i >> {offset_i, 3'b000};
    assign sh64    = 64'(sh);

    // Extension is done at 64 bits; the top never passes SZ_D at XLEN=32.
    always_comb begin
        ext = sh64;
        unique case (size_i)
            SZ_B: ext = {{56{~unsigned_i & sh64[7]}}, sh64[7:0]};
            SZ_H: ext = {{48{~unsigned_i & sh64[15]}}, sh64[15:0]};
            SZ_W: ext = {{32{~unsigned_i & sh64[31]}}, sh64[31:0]};
            default: ext = sh64;
        endcase
    end

    assign rdata_o = ext[XLEN-1:0];

endmodule

// File: rtl/mem_access_ahb.sv
// MEM pipeline stage: one load/store per instruction over an AHB-lite master.
// Optional `MEM_ACCESS_MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned accesses.
module mem_access_ahb
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [2:0]        FUNCT3,
    input  logic [4:0]        rd_i,
    input  logic [ADDR_W-1:0] address,
    input  logic [XLEN-1:0]   value,
    input  logic [XLEN-1:0]   alu_res,
    input  logic              write_back,
    input  logic              branch_flag_i,
    input  logic [XLEN-1:0]   branch_offset_i,
    input  logic [ADDR_W-1:0] PC_i,
    input  logic [XLEN-1:0]   HRDATA,
    input  logic              HREADY,
    output logic [ADDR_W-1:0] HADDR,
    output logic [XLEN-1:0]   HWDATA,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [XLEN-1:0]   res,
    output logic [4:0]        rd_o,
    output logic              mem_write_back_en,
    output logic              take_branch,
    output logic [XLEN-1:0]   branch_offset_o,
    output logic [ADDR_W-1:0] PC_o,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              busy
);

    localparam int LANE_W = $clog2(XLEN/8);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [XLEN-1:0]   hwdata_q, hwdata_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_q, wb_d;
    logic              tb_q, tb_d;
    logic [XLEN-1:0]   boff_q, boff_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              uns_q, uns_d;
    logic [4:0]        rdi_q, rdi_d;
    logic              wbi_q, wbi_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   val_q, val_d;

    logic [1:0]        sz_eff;
    logic              mis;
    logic              accept;
    logic [XLEN-1:0]   wlane;
    logic [XLEN-1:0]   rext;

    // A doubleword at XLEN=32 degrades to a word access.
    assign sz_eff = (XLEN == 32 && FUNCT3[1:0] == SZ_D) ? SZ_W : FUNCT3[1:0];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis = misaligned(sz_eff, address[2:0]);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) mis_q <= 1'b0;
        else        mis_q <= state_q == S_IDLE && EN && !tb_q && mis;
    end
    assign misalign_o = mis_q;
`else
    assign mis = 1'b0;
`endif

    assign accept = state_q == S_IDLE && EN && !tb_q && !mis;
    assign busy   = RST_N && (state_q != S_IDLE || accept);

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size_i     (hsize_q[1:0]),
        .unsigned_i (uns_q),
        .offset_i   (haddr_q[LANE_W-1:0]),
        .wdata_i    (val_q),
        .rdata_i    (HRDATA),
        .wlane_o    (wlane),
        .rdata_o    (rext)
    );

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        hwrite_d = hwrite_q;
        htrans_d = htrans_q;
        hsize_d  = hsize_q;
        res_d    = res_q;
        rd_d     = '0;
        wb_d     = 1'b0;
        tb_d     = 1'b0;
        boff_d   = boff_q;
        pc_d     = pc_q;
        uns_d    = uns_q;
        rdi_d    = rdi_q;
        wbi_d    = wbi_q;
        alu_d    = alu_q;
        val_d    = val_q;
        unique case (state_q)
            S_IDLE: begin
                pc_d     = PC_i;
                boff_d   = branch_offset_i;
                htrans_d = HTRANS_IDLE;
                if (accept) begin
                    state_d  = S_ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = address;
                    hwrite_d = ~LOAD;
                    hsize_d  = {1'b0, sz_eff};
                    uns_d    = FUNCT3[2];
                    rdi_d    = rd_i;
                    wbi_d    = write_back;
                    alu_d    = alu_res;
                    val_d    = value;
                end else if (!tb_q && !EN) begin
                    res_d = alu_res;
                    rd_d  = rd_i;
                    wb_d  = write_back;
                    tb_d  = branch_flag_i && alu_res == XLEN'(1);
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) hwdata_d = wlane;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    state_d = S_IDLE;
                    res_d   = hwrite_q ? alu_q : rext;
                    rd_d    = rdi_q;
                    wb_d    = wbi_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hsize_q  <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            tb_q     <= 1'b0;
            boff_q   <= '0;
            pc_q     <= '0;
            uns_q    <= 1'b0;
            rdi_q    <= '0;
            wbi_q    <= 1'b0;
            alu_q    <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            hsize_q  <= hsize_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            tb_q     <= tb_d;
            boff_q   <= boff_d;
            pc_q     <= pc_d;
            uns_q    <= uns_d;
            rdi_q    <= rdi_d;
            wbi_q    <= wbi_d;
            alu_q    <= alu_d;
            val_q    <= val_d;
        end
    end

    a_no_dword_xlen32: assert property (@(posedge CLK) disable iff (!RST_N)
        !(accept && XLEN == 32 && FUNCT3[1:0] == SZ_D));

    assign HADDR             = haddr_q;
    assign HWDATA            = hwdata_q;
    assign HWRITE            = hwrite_q;
    assign HTRANS            = htrans_q;
    assign HSIZE             = hsize_q;
    assign res               = res_q;
    assign rd_o              = rd_q;
    assign mem_write_back_en = wb_q;
    assign take_branch       = tb_q;
    assign branch_offset_o   = boff_q;
    assign PC_o              = pc_q;

endmodule

// File: tb/tb_mem_access_ahb.sv
// Randomised self-checking bench for mem_access_ahb (XLEN=64) against
// a byte-level reference model of loads, stores, branches and squashes.
module tb_mem_access_ahb;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        LOAD = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [4:0]  rd_i = '0;
    logic [63:0] address = '0;
    logic [63:0] value = '0;
    logic [63:0] alu_res = '0;
    logic        write_back = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [63:0] branch_offset_i = '0;
    logic [63:0] PC_i = '0;
    logic [63:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [63:0] res;
    logic [4:0]  rd_o;
    logic        mem_write_back_en;
    logic        take_branch;
    logic [63:0] branch_offset_o;
    logic [63:0] PC_o;
    logic        busy;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;

    mem_access_ahb #(.XLEN(64), .ADDR_W(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .FUNCT3(FUNCT3),
        .rd_i(rd_i), .address(address), .value(value), .alu_res(alu_res),
        .write_back(write_back), .branch_flag_i(branch_flag_i),
        .branch_offset_i(branch_offset_i), .PC_i(PC_i), .HRDATA(HRDATA),
        .HREADY(HREADY), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .res(res), .rd_o(rd_o),
        .mem_write_back_en(mem_write_back_en), .take_branch(take_branch),
        .branch_offset_o(branch_offset_o), .PC_o(PC_o),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (busy) busy_cnt++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] d,
                                             input logic [63:0] a,
                                             input logic [2:0] f3);
        int n = 1 << f3[1:0];
        int off = int'(a[2:0]);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
        if (!f3[2] && r[8*n-1])
            for (int i = 8 * n; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic bubble();
        EN = 1'b0;
        write_back = 1'b0;
        branch_flag_i = 1'b0;
    endtask

    task automatic mem_op(input string tag, input logic ld,
                          input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] v, input logic [63:0] rdata,
                          input int wa, input int wd);
        logic [4:0]  rd = 5'($urandom_range(1, 31));
        logic [63:0] alu = {$urandom, $urandom};
        logic [63:0] got_m = '0;
        logic [63:0] exp_m = '0;
        int b0 = busy_cnt;
        int n = 1 << f3[1:0];
        int off = int'(a[2:0]);
        EN = 1'b1; LOAD = ld; FUNCT3 = f3; address = a; value = v;
        rd_i = rd; write_back = ld; alu_res = alu; branch_flag_i = 1'b0;
        HREADY = 1'b1; HRDATA = '0;
        #1 chk({tag, " busy_issue"}, busy, 1);
        tick();
        chk({tag, " htrans_nonseq"}, HTRANS, 2'b10);
        chk({tag, " haddr"}, HADDR, a);
        chk({tag, " hwrite"}, HWRITE, !ld);
        chk({tag, " hsize"}, HSIZE, {1'b0, f3[1:0]});
        chk({tag, " wb_early"}, mem_write_back_en, 0);
        HREADY = 1'b0;
        repeat (wa) begin
            tick();
            chk({tag, " addr_hold"}, HTRANS, 2'b10);
        end
        HREADY = 1'b1;
        tick();
        chk({tag, " htrans_idle"}, HTRANS, 2'b00);
        if (!ld) begin
            for (int i = 0; i < n; i++)
                if (off + i < 8) begin
                    got_m[8*i +: 8] = HWDATA[8*(off+i) +: 8];
                    exp_m[8*i +: 8] = v[8*i +: 8];
                end
            chk({tag, " hwdata_lanes"}, got_m, exp_m);
        end
        HREADY = 1'b0;
        HRDATA = ~rdata;
        repeat (wd) begin
            tick();
            chk({tag, " data_wait_wb"}, mem_write_back_en, 0);
        end
        HREADY = 1'b1;
        HRDATA = rdata;
        tick();
        chk({tag, " res"}, res, ld ? ref_load(rdata, a, f3) : alu);
        chk({tag, " rd_o"}, rd_o, rd);
        chk({tag, " wb"}, mem_write_back_en, ld);
        chk({tag, " busy_cycles"}, 64'(busy_cnt - b0), 64'(3 + wa + wd));
        bubble();
        #1 chk({tag, " busy_done"}, busy, 0);
    endtask

    task automatic pass_op(input string tag, input logic bf,
                           input logic [63:0] alu, output logic taken);
        logic [4:0]  rd = 5'($urandom);
        logic        wb = 1'($urandom);
        logic [63:0] pc = {$urandom, $urandom};
        logic [63:0] bo = {$urandom, $urandom};
        EN = 1'b0; rd_i = rd; write_back = wb; alu_res = alu;
        branch_flag_i = bf; PC_i = pc; branch_offset_i = bo;
        tick();
        taken = bf && alu == 64'd1;
        chk({tag, " res"}, res, alu);
        chk({tag, " rd_o"}, rd_o, rd);
        chk({tag, " wb"}, mem_write_back_en, wb);
        chk({tag, " take_branch"}, take_branch, taken);
        chk({tag, " pc_o"}, PC_o, pc);
        chk({tag, " boff_o"}, branch_offset_o, bo);
        bubble();
    endtask

    task automatic squash_op(input string tag);
        EN = 1'b1; LOAD = 1'b1; FUNCT3 = 3'd2; address = 64'h3000;
        rd_i = 5'd9; write_back = 1'b1;
        #1 chk({tag, " busy"}, busy, 0);
        tick();
        chk({tag, " htrans"}, HTRANS, 2'b00);
        chk({tag, " rd_o"}, rd_o, 0);
        chk({tag, " wb"}, mem_write_back_en, 0);
        chk({tag, " take_branch"}, take_branch, 0);
        bubble();
    endtask

    initial begin
        logic tk;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst htrans", HTRANS, 0);
        chk("rst busy", busy, 0);
        chk("rst res", res, 0);
        chk("rst rd_o", rd_o, 0);
        chk("rst wb", mem_write_back_en, 0);
        chk("rst tb", take_branch, 0);
        chk("rst haddr", HADDR, 0);
        chk("rst hwdata", HWDATA, 0);
        RST_N = 1'b1;
        tick();

        mem_op("lw", 1'b1, 3'd2, 64'h1004, 64'h0, 64'hDEAD_BEEF_8000_0000, 0, 0);
        chk("lw const", res, 64'hFFFF_FFFF_DEAD_BEEF);
        mem_op("sb", 1'b0, 3'd0, 64'h1003, 64'hAB, 64'h0, 0, 0);
        chk("sb lane", HWDATA[31:24], 8'hAB);
        mem_op("lbu", 1'b1, 3'd4, 64'h2007, 64'h0, 64'h9A00_0000_0000_0000, 0, 3);
        chk("lbu const", res, 64'h9A);
        mem_op("sd_wait", 1'b0, 3'd3, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1);

        pass_op("br", 1'b1, 64'd1, tk);
        chk("br taken", tk, 1);
        squash_op("squash");
        pass_op("br_nt", 1'b1, 64'd2, tk);
        pass_op("plain", 1'b0, 64'd1, tk);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                pass_op("rnd_pass", 1'($urandom), 64'($urandom_range(0, 2)), tk);
                if (tk) squash_op("rnd_squash");
            end else begin
                logic [2:0]  f3 = 3'($urandom);
                logic [63:0] a = {$urandom, $urandom};
                logic [63:0] msk = 64'((1 << f3[1:0]) - 1);
                logic        ld = 1'($urandom);
                if (!ld) f3[2] = 1'b0;
                a = a & ~msk;
                mem_op("rnd_mem", ld, f3, a, {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom_range(0, 2),
                       $urandom_range(0, 2));
            end
        end

        EN = 1'b1; LOAD = 1'b1; FUNCT3 = 3'd2; address = 64'h5000;
        rd_i = 5'd3; write_back = 1'b1; HREADY = 1'b1;
        tick();
        tick();
        HREADY = 1'b0;
        tick();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mid htrans", HTRANS, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid wb", mem_write_back_en, 0);
        tick();
        bubble();
        HREADY = 1'b1;
        RST_N = 1'b1;
        tick();
        chk("post_rst busy", busy, 0);
        pass_op("post_rst", 1'b0, 64'h55, tk);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        EN = 1'b1; LOAD = 1'b1; FUNCT3 = 3'd2; address = 64'h1002;
        rd_i = 5'd4; write_back = 1'b1;
        #1 chk("mis busy", busy, 0);
        tick();
        chk("mis pulse", misalign_o, 1);
        chk("mis htrans", HTRANS, 0);
        chk("mis rd_o", rd_o, 0);
        chk("mis wb", mem_write_back_en, 0);
        bubble();
        tick();
        chk("mis clear", misalign_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
